// File: rtl/arb_pkg.sv
// Shared types for the two-input round-robin arbiter.
// Buffer state encoding and priority pointer values.
package arb_pkg;

  typedef enum logic {
    ARB_EMPTY,
    ARB_FULL
  } arb_state_t;

  localparam logic ARB_PRIO_IN0 = 1'b0;
  localparam logic ARB_PRIO_IN1 = 1'b1;

endpackage

// File: rtl/Mux2_RTL.sv
// Two-way message multiplexer.
// sel = 0 passes in0, sel = 1 passes in1.
module Mux2_RTL #(
  parameter int p_nbits = 32
) (
  input  logic               sel,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/arb2_rr_rtl.sv
// Round-robin arbiter: two val/rdy requesters into a one-entry
// output buffer, one message per cycle at full throughput.
module arb2_rr_rtl
  import arb_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_src
);

  arb_state_t         state;
  logic               prio;
  logic               can_acc;
  logic               grant0;
  logic               grant1;
  logic               grant;
  logic [p_nbits-1:0] mux_out;

  // reset gates acceptance so rdy stays low while reset is held
  assign can_acc = !reset &&
                   ((state == ARB_EMPTY) || out_rdy);

  assign grant0 = can_acc && in0_val &&
                  (!in1_val || prio == ARB_PRIO_IN0);
  assign grant1 = can_acc && in1_val &&
                  (!in0_val || prio == ARB_PRIO_IN1);
  assign grant  = grant0 || grant1;

  assign in0_rdy = grant0;
  assign in1_rdy = grant1;
  assign out_val = (state == ARB_FULL);

  Mux2_RTL #(
    .p_nbits(p_nbits)
  ) u_mux (
    .sel(grant1),
    .in0(in0_msg),
    .in1(in1_msg),
    .out(mux_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB_EMPTY;
      prio    <= ARB_PRIO_IN0;
      out_msg <= '0;
      out_src <= 1'b0;
    end else begin
      unique case (state)
        ARB_EMPTY: begin
          if (grant) state <= ARB_FULL;
        end
        ARB_FULL: begin
          if (out_rdy && !grant) state <= ARB_EMPTY;
        end
      endcase
      if (grant) begin
        out_msg <= mux_out;
        out_src <= grant1;
        prio    <= grant0 ? ARB_PRIO_IN1
                          : ARB_PRIO_IN0;
      end
    end
  end

endmodule

// File: tb/tb_arb2_rr_rtl.sv
// Bench for arb2_rr_rtl: directed vectors plus a random phase,
// with a queue scoreboard drained by an output monitor.
module tb_arb2_rr_rtl;

  logic        clk;
  logic        reset;
  logic        in0_val;
  logic        in0_rdy;
  logic [31:0] in0_msg;
  logic        in1_val;
  logic        in1_rdy;
  logic [31:0] in1_msg;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
  logic        out_src;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] q[$];

  // reference model state
  logic m_full;
  logic m_prio;

  arb2_rr_rtl #(.p_nbits(32)) dut (
    .clk(clk),
    .reset(reset),
    .in0_val(in0_val),
    .in0_rdy(in0_rdy),
    .in0_msg(in0_msg),
    .in1_val(in1_val),
    .in1_rdy(in1_rdy),
    .in1_msg(in1_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg),
    .out_src(out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [32:0] act,
                     input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // output monitor: front of queue must be what is presented
  always @(negedge clk) begin
    if (!reset && out_val) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {out_src, out_msg}, 33'h0);
        n_bad += (out_msg == 0 && !out_src) ? 1 : 0;
      end else begin
        chk("sb_out", {out_src, out_msg}, q[0]);
        if (out_rdy) void'(q.pop_front());
      end
    end
  end

  task automatic do_rst;
    reset = 1'b1;
    #1;
    chk("rst_outval", {32'h0, out_val}, 33'h0);
    chk("rst_rdy", {31'h0, in1_rdy, in0_rdy}, 33'h0);
    #1;
    reset  = 1'b0;
    m_full = 1'b0;
    m_prio = 1'b0;
    q.delete();
  endtask

  // called at posedge+1; returns at next posedge+1
  task automatic step(input  logic        v0,
                      input  logic [31:0] d0,
                      input  logic        v1,
                      input  logic [31:0] d1,
                      input  logic        ordy,
                      output logic        g0,
                      output logic        g1);
    logic can;
    in0_val = v0;
    in0_msg = d0;
    in1_val = v1;
    in1_msg = d1;
    out_rdy = ordy;
    @(negedge clk);
    can = !m_full || ordy;
    g0  = can && v0 && (!v1 || !m_prio);
    g1  = can && v1 && (!v0 || m_prio);
    chk("in0_rdy", {32'h0, in0_rdy}, {32'h0, g0});
    chk("in1_rdy", {32'h0, in1_rdy}, {32'h0, g1});
    chk("excl", {32'h0, in0_rdy && in1_rdy}, 33'h0);
    chk("out_val", {32'h0, out_val}, {32'h0, m_full});
    if (g0) q.push_back({1'b0, d0});
    if (g1) q.push_back({1'b1, d1});
    @(posedge clk);
    if (g0 || g1) begin
      m_full = 1'b1;
      m_prio = g0;
    end else if (ordy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  logic        g0, g1;
  logic        p0, p1;
  logic [31:0] r0, r1;
  int          w0, w1;
  logic [31:0] exp_msg [4];
  logic        exp_src [4];

  initial begin
    reset   = 1'b1;
    in0_val = 1'b1;
    in1_val = 1'b1;
    in0_msg = 32'h5;
    in1_msg = 32'h6;
    out_rdy = 1'b1;
    m_full  = 1'b0;
    m_prio  = 1'b0;

    // reset with both requesters active
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_outval", {32'h0, out_val}, 33'h0);
    chk("t1_rdy", {31'h0, in1_rdy, in0_rdy}, 33'h0);
    chk("t1_outmsg", {1'b0, out_msg}, 33'h0);
    chk("t1_outsrc", {32'h0, out_src}, 33'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single requester streaming
    step(1'b1, 32'hAA, 1'b0, 32'h0, 1'b1, g0, g1);
    chk("t2_val", {32'h0, out_val}, 33'h1);
    chk("t2_msg", {out_src, out_msg}, {1'b0, 32'hAA});
    step(1'b1, 32'hAB, 1'b0, 32'h0, 1'b1, g0, g1);
    chk("t2_msg2", {out_src, out_msg}, {1'b0, 32'hAB});
    step(1'b1, 32'hAC, 1'b0, 32'h0, 1'b1, g0, g1);
    chk("t2_msg3", {out_src, out_msg}, {1'b0, 32'hAC});

    // contention from reset
    do_rst();
    exp_msg = '{32'h11, 32'h22, 32'h11, 32'h22};
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h11, 1'b1, 32'h22, 1'b1, g0, g1);
      chk("t3_seq", {out_src, out_msg},
          {exp_src[i], exp_msg[i]});
    end

    // back-pressure with 0x11 buffered
    do_rst();
    step(1'b1, 32'h11, 1'b1, 32'h22, 1'b1, g0, g1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h11, 1'b1, 32'h22, 1'b0, g0, g1);
      chk("t4_hold", {out_src, out_msg}, {1'b0, 32'h11});
      chk("t4_nogrant", {31'h0, g1, g0}, 33'h0);
    end
    step(1'b1, 32'h11, 1'b1, 32'h22, 1'b1, g0, g1);
    chk("t4_in1_win", {31'h0, g1, g0}, 33'h2);
    chk("t4_next", {out_src, out_msg}, {1'b1, 32'h22});

    // drain without refill; prio must stay favouring in0
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g0, g1);
    chk("t5_empty", {32'h0, out_val}, 33'h0);
    step(1'b1, 32'h33, 1'b1, 32'h44, 1'b1, g0, g1);
    chk("t5_prio", {out_src, out_msg}, {1'b0, 32'h33});

    // reset mid-operation with 0x22 buffered
    step(1'b0, 32'h0, 1'b1, 32'h22, 1'b0, g0, g1);
    step(1'b0, 32'h0, 1'b1, 32'h22, 1'b1, g0, g1);
    chk("t6_full", {out_src, out_msg}, {1'b1, 32'h22});
    do_rst();
    chk("t6_clear", {32'h0, out_val}, 33'h0);
    step(1'b1, 32'h55, 1'b1, 32'h66, 1'b1, g0, g1);
    chk("t6_in0_first", {out_src, out_msg}, {1'b0, 32'h55});

    // random phase; requesters hold a message until accepted
    p0 = 1'b0;
    p1 = 1'b0;
    r0 = '0;
    r1 = '0;
    w0 = 0;
    w1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (!p0) begin
        p0 = 1'($urandom_range(0, 1));
        r0 = $urandom;
      end
      if (!p1) begin
        p1 = 1'($urandom_range(0, 1));
        r1 = $urandom;
      end
      step(p0, r0, p1, r1, 1'($urandom_range(0, 1)),
           g0, g1);
      if (p0) begin
        w0 = g0 ? 0 : (g1 ? w0 + 1 : w0);
        chk("fair0", {32'h0, w0 > 1}, 33'h0);
      end
      if (p1) begin
        w1 = g1 ? 0 : (g0 ? w1 + 1 : w1);
        chk("fair1", {32'h0, w1 > 1}, 33'h0);
      end
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end

    repeat (3) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, g0, g1);
    chk("drained", {1'b0, 32'(q.size())}, 33'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
